// File: rtl/piso_frame_serializer.sv
// Parallel-in/serial-out word serializer with valid/ready intake, programmable
// bit hold time and optional start(0)/stop(1) framing. Data is sent LSB-first.
module piso_frame_serializer #(
    parameter int WIDTH      = 4,
    parameter int BIT_CYCLES = 1,
    parameter int FRAMED     = 1
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic             out_o,
    output logic             out_valid_o,
    output logic             busy_o
);

    localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   sreg_q, sreg_d;
    logic               out_q, out_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic               bit_end;

    assign in_ready_o  = (state_q == S_IDLE) & ~srst_i;
    assign out_o       = out_q;
    assign out_valid_o = out_valid_q;
    assign busy_o      = busy_q;

    assign bit_end = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sreg_d  = sreg_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid_i && in_ready_o) begin
                    sreg_d  = in_data_i;
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = (FRAMED != 0) ? S_START : S_DATA;
                end
            end
            S_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = (FRAMED != 0) ? S_STOP : S_IDLE;
                    end else begin
                        idx_d  = idx_q + IDX_W'(1);
                        sreg_d = sreg_q >> 1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so the first frame bit
        // appears on the line directly after the accepting edge.
        out_d       = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = (state_d != S_IDLE);
        if (state_d == S_START) begin
            out_d = 1'b0;
        end else if (state_d == S_DATA) begin
            out_d       = sreg_d[0];
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            sreg_q      <= '0;
            out_q       <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            sreg_q      <= sreg_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

endmodule

// File: tb/tb_piso_frame_serializer.sv
// Bench for piso_frame_serializer: four parameterisations driven side by side,
// each frame compared cycle by cycle with a frame built from the bit-level rules.
module tb_piso_frame_serializer;

    localparam int W_T  [4] = '{4, 4, 4, 1};
    localparam int BC_T [4] = '{1, 3, 1, 1};
    localparam int F_T  [4] = '{0, 1, 1, 1};

    logic       clk;
    logic       srst;
    logic [3:0] d_in [4];
    logic       v_in [4];
    logic       o    [4];
    logic       ov   [4];
    logic       rdy  [4];
    logic       bsy  [4];

    logic exp_out [$];
    logic exp_val [$];
    logic [31:0] rec_out;
    logic [3:0]  sipo;
    int n_checks;
    int n_pass;

    piso_frame_serializer #(.WIDTH(4), .BIT_CYCLES(1), .FRAMED(0)) dut_raw (
        .clk_i(clk), .srst_i(srst), .in_data_i(d_in[0]), .in_valid_i(v_in[0]),
        .in_ready_o(rdy[0]), .out_o(o[0]), .out_valid_o(ov[0]), .busy_o(bsy[0]));

    piso_frame_serializer #(.WIDTH(4), .BIT_CYCLES(3), .FRAMED(1)) dut_frm3 (
        .clk_i(clk), .srst_i(srst), .in_data_i(d_in[1]), .in_valid_i(v_in[1]),
        .in_ready_o(rdy[1]), .out_o(o[1]), .out_valid_o(ov[1]), .busy_o(bsy[1]));

    piso_frame_serializer #(.WIDTH(4), .BIT_CYCLES(1), .FRAMED(1)) dut_frm1 (
        .clk_i(clk), .srst_i(srst), .in_data_i(d_in[2]), .in_valid_i(v_in[2]),
        .in_ready_o(rdy[2]), .out_o(o[2]), .out_valid_o(ov[2]), .busy_o(bsy[2]));

    piso_frame_serializer #(.WIDTH(1), .BIT_CYCLES(1), .FRAMED(1)) dut_w1 (
        .clk_i(clk), .srst_i(srst), .in_data_i(d_in[3][0:0]), .in_valid_i(v_in[3]),
        .in_ready_o(rdy[3]), .out_o(o[3]), .out_valid_o(ov[3]), .busy_o(bsy[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: list the frame's bits, then stretch each one BIT_CYCLES times.
    task automatic build_frame(input int sel, input logic [3:0] word);
        logic bq [$];
        logic vq [$];
        exp_out.delete();
        exp_val.delete();
        if (F_T[sel] != 0) begin bq.push_back(1'b0); vq.push_back(1'b0); end
        for (int b = 0; b < W_T[sel]; b++) begin
            bq.push_back(word[b]);
            vq.push_back(1'b1);
        end
        if (F_T[sel] != 0) begin bq.push_back(1'b1); vq.push_back(1'b0); end
        foreach (bq[j]) begin
            for (int c = 0; c < BC_T[sel]; c++) begin
                exp_out.push_back(bq[j]);
                exp_val.push_back(vq[j]);
            end
        end
    endtask

    task automatic run_frame(input int sel, input logic [3:0] word);
        int errs;
        errs = 0;
        build_frame(sel, word);
        v_in[sel] = 1'b1;
        d_in[sel] = word;
        n_checks++;
        if (rdy[sel] !== 1'b1) begin
            $display("FAIL ready_before_accept sel=%0d got=%b want=1", sel, rdy[sel]);
            errs++;
        end else n_pass++;
        @(posedge clk); #1;
        v_in[sel] = 1'b0;
        d_in[sel] = 4'($urandom);
        rec_out = '0;
        sipo = '0;
        for (int i = 0; i < exp_out.size(); i++) begin
            n_checks++;
            if ({o[sel], ov[sel], bsy[sel], rdy[sel]} !== {exp_out[i], exp_val[i], 1'b1, 1'b0}) begin
                $display("FAIL frame_cycle sel=%0d i=%0d got out/valid/busy/ready=%b%b%b%b want=%b%b10",
                         sel, i, o[sel], ov[sel], bsy[sel], rdy[sel], exp_out[i], exp_val[i]);
                errs++;
            end else n_pass++;
            rec_out[i] = o[sel];
            if (exp_val[i] && (i % BC_T[sel] == BC_T[sel] / 2)) sipo = {o[sel], sipo[3:1]};
            @(posedge clk); #1;
        end
        n_checks++;
        if ({o[sel], ov[sel], bsy[sel], rdy[sel]} !== 4'b1001) begin
            $display("FAIL idle_after_frame sel=%0d got=%b%b%b%b want=1001",
                     sel, o[sel], ov[sel], bsy[sel], rdy[sel]);
            errs++;
        end else n_pass++;
        $display("frame sel=%0d word=%h cycles=%0d errors=%0d", sel, word, exp_out.size(), errs);
    endtask

    task automatic test_reset();
        srst = 1'b1;
        for (int s = 0; s < 4; s++) begin v_in[s] = 1'b1; d_in[s] = 4'($urandom); end
        repeat (3) begin
            @(posedge clk); #1;
            for (int s = 0; s < 4; s++) begin
                n_checks++;
                if ({o[s], ov[s], bsy[s], rdy[s]} !== 4'b1000) begin
                    $display("FAIL reset_hold sel=%0d got=%b%b%b%b want=1000", s, o[s], ov[s], bsy[s], rdy[s]);
                end else n_pass++;
            end
        end
        srst = 1'b0;
        for (int s = 0; s < 4; s++) v_in[s] = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            for (int s = 0; s < 4; s++) begin
                n_checks++;
                if ({o[s], ov[s], bsy[s], rdy[s]} !== 4'b1001) begin
                    $display("FAIL post_reset_idle sel=%0d got=%b%b%b%b want=1001", s, o[s], ov[s], bsy[s], rdy[s]);
                end else n_pass++;
            end
        end
        $display("reset done");
    endtask

    task automatic test_raw();
        run_frame(0, 4'b1011);
        n_checks++;
        if (rec_out[3:0] !== 4'b1011) $display("FAIL raw_bits got=%b want=1011", rec_out[3:0]);
        else n_pass++;
    endtask

    task automatic test_framed();
        run_frame(1, 4'b0110);
        n_checks++;
        if (rec_out[17:0] !== 18'h38FC0) $display("FAIL framed_wave got=%h want=38fc0", rec_out[17:0]);
        else n_pass++;
        n_checks++;
        if (sipo !== 4'b0110) $display("FAIL framed_sipo got=%b want=0110", sipo);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic eo [$];
        logic ev [$];
        logic eb [$];
        logic er [$];
        build_frame(2, 4'hA);
        foreach (exp_out[i]) begin eo.push_back(exp_out[i]); ev.push_back(exp_val[i]); eb.push_back(1'b1); er.push_back(1'b0); end
        eo.push_back(1'b1); ev.push_back(1'b0); eb.push_back(1'b0); er.push_back(1'b1);
        build_frame(2, 4'h5);
        foreach (exp_out[i]) begin eo.push_back(exp_out[i]); ev.push_back(exp_val[i]); eb.push_back(1'b1); er.push_back(1'b0); end
        eo.push_back(1'b1); ev.push_back(1'b0); eb.push_back(1'b0); er.push_back(1'b1);
        v_in[2] = 1'b1;
        d_in[2] = 4'hA;
        @(posedge clk); #1;
        d_in[2] = 4'h5;
        for (int i = 0; i < eo.size(); i++) begin
            n_checks++;
            if ({o[2], ov[2], bsy[2], rdy[2]} !== {eo[i], ev[i], eb[i], er[i]}) begin
                $display("FAIL b2b_cycle i=%0d got=%b%b%b%b want=%b%b%b%b",
                         i, o[2], ov[2], bsy[2], rdy[2], eo[i], ev[i], eb[i], er[i]);
            end else n_pass++;
            if (i == 7) v_in[2] = 1'b0;
            @(posedge clk); #1;
        end
        $display("back_to_back words A,5 cycles=%0d", eo.size());
    endtask

    task automatic test_abort();
        v_in[2] = 1'b1;
        d_in[2] = 4'($urandom);
        @(posedge clk); #1;
        v_in[2] = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        n_checks++;
        if (ov[2] !== 1'b1) $display("FAIL abort_in_data got=%b want=1", ov[2]);
        else n_pass++;
        srst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({o[2], ov[2], bsy[2], rdy[2]} !== 4'b1000)
            $display("FAIL abort_reset got=%b%b%b%b want=1000", o[2], ov[2], bsy[2], rdy[2]);
        else n_pass++;
        srst = 1'b0;
        #1;
        n_checks++;
        if (rdy[2] !== 1'b1) $display("FAIL abort_ready got=%b want=1", rdy[2]);
        else n_pass++;
        $display("abort done");
        run_frame(2, 4'hF);
    endtask

    task automatic test_edge_params();
        run_frame(3, 4'h0);
        n_checks++;
        if (rec_out[2:0] !== 3'b100) $display("FAIL w1_bits got=%b want=100", rec_out[2:0]);
        else n_pass++;
        run_frame(3, 4'h1);
    endtask

    task automatic test_random();
        logic [3:0] w;
        for (int r = 0; r < 6; r++) begin
            for (int s = 0; s < 4; s++) begin
                w = 4'($urandom);
                if (W_T[s] == 1) w = w & 4'h1;
                run_frame(s, w);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        srst     = 1'b1;
        for (int s = 0; s < 4; s++) begin v_in[s] = 1'b0; d_in[s] = '0; end
        @(posedge clk); #1;
        test_reset();
        test_raw();
        test_framed();
        test_back_to_back();
        test_abort();
        test_edge_params();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
